lzd_norm_seq: RTL and testbench
===============================

// Module: lzd_norm_seq
// PURPOSE
//  Sequential leading-zero normalizer for the Box-Muller AWGN datapath (log/sqrt operand prep).
//  Time-shares one 8-bit leading-zero detector (LZDeight: a[7:0] -> p[2:0] byte LZ count, v = byte nonzero)
//  over a DATA_W-bit operand, scanning one byte per cycle MSB-first.
//  Returns the left-normalized operand plus its total leading-zero count.
//  Valid/ready handshakes on input and output; one operand in flight at a time.
// PARAMETERS
//  DATA_W  48  operand width; multiple of 8, 16..64
//  LZC_W   6   count width; must satisfy 2**LZC_W > DATA_W
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        operand offered
//  in_ready   out  1        block can accept (IDLE only)
//  in_data    in   DATA_W   operand
//  out_valid  out  1        result held
//  out_ready  in   1        consumer accepts result
//  out_data   out  DATA_W   in_data << out_lzc (zero-filled); all zeros if operand zero
//  out_lzc    out  LZC_W    leading-zero count, 0..DATA_W
//  out_zero   out  1        operand was all zeros (out_lzc == DATA_W)
// BEHAVIOUR
//  - Reset (rst_n low at edge): state IDLE; in_ready=1 after reset; out_valid=0, out_data=0, out_lzc=0,
//    out_zero=0; working reg, byte index and count cleared. Reset wins over every other event, any state.
//  - FSM: IDLE -> SCAN -> DONE -> IDLE. NB = DATA_W/8.
//  - IDLE: in_ready=1. in_valid&in_ready at edge: wreg<=in_data, cnt<=0, idx<=0, go SCAN.
//  - SCAN: in_ready=0. LZD sees wreg[DATA_W-1 -: 8] (combinational, same cycle).
//    v=1: cnt<=cnt+p; wreg<=wreg<<p; go DONE.
//    v=0 and idx<NB-1: cnt<=cnt+8; wreg<=wreg<<8; idx<=idx+1; stay SCAN.
//    v=0 and idx==NB-1: cnt<=DATA_W; wreg<=0; zero flag<=1; go DONE.
//  - DONE: out_valid=1; out_data/out_lzc/out_zero stable while out_valid & !out_ready.
//    out_valid&out_ready at edge: go IDLE, out_valid<=0. Outputs keep last value (don't-care once invalid).
//  - Latency: k = leading all-zero bytes. SCAN cycles S = min(k+1, NB). out_valid rises S+1 edges after
//    the accepting edge (1 edge IDLE->SCAN, S edges in SCAN).
//  - Throughput: one operand per S+2 cycles minimum. in_ready is never high while SCAN or DONE.
//  - Arithmetic: cnt is LZC_W bits; never exceeds DATA_W, no wrap. Shift amount p is 0..7. Bits shifted in
//    are zero.
//  - Simultaneous: in_valid during SCAN/DONE is ignored, not dropped-and-acked. No same-cycle DONE->accept
//    bypass; a new operand waits one IDLE cycle.
//  - Mid-operation reset: in-flight operand discarded. No out_valid pulse produced.
//  - Unknown/illegal state encoding: return to IDLE next edge.
// CONFIGURATION
//  LZDN_PERF_EN defined:
//    - Adds output perf_scan_cyc [15:0]: counts SCAN cycles since reset.
//    - Saturates at 16'hFFFF. Reset to 0 by rst_n.
//  LZDN_PERF_EN undefined: port and counter absent. All other behaviour identical.
// TESTING (DATA_W=48, LZC_W=6)
//  1. Reset: rst_n low 2 cycles, then release -> out_valid=0, out_lzc=0, in_ready=1 on the first cycle after.
//  2. in_data=48'h8000_0000_0000 -> S=1, out_valid 2 edges after accept, out_lzc=0, out_data unchanged,
//     out_zero=0.
//  3. in_data=48'h0000_0000_0013 -> S=6, out_lzc=43, out_data=48'h9800_0000_0000, out_zero=0.
//  4. in_data=0 -> S=6, out_lzc=48, out_data=0, out_zero=1.
//  5. Backpressure: in_data=48'h0001_0000_0000, out_ready=0 for 5 cycles -> out_lzc=15 held stable, in_ready=0;
//     in_valid pulsed meanwhile is not accepted. Accepted on out_ready=1, then IDLE.
//  6. Reset mid-SCAN (in_data=0, rst_n low at 3rd SCAN cycle) -> no out_valid, IDLE.
//     Next operand 48'h00FF_0000_0000 -> out_lzc=8. With LZDN_PERF_EN, perf_scan_cyc=2.

Source files
------------

// File: rtl/lzd_norm_seq.sv
// lzd_norm_seq
//   Sequential leading-zero normalizer for operand preparation in a Box-Muller
//   AWGN datapath (log/sqrt stages). One 8-bit leading-zero detector is
//   time-shared across a DATA_W-bit operand, scanning one byte per cycle,
//   MSB-first. The result is the left-normalized operand together with its
//   total leading-zero count. One operand is in flight at a time.
//
//   Optional feature macro: LZDN_PERF_EN
//     When defined, adds perf_scan_cyc[15:0], a saturating count of SCAN
//     cycles since the last reset.
//
// Parameters
//   DATA_W  operand width, multiple of 8, 16..64
//   LZC_W   count width, 2**LZC_W > DATA_W
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous reset, active low
//   in_valid       operand offered
//   in_ready       block can accept an operand (idle only)
//   in_data        operand
//   out_valid      result is being held
//   out_ready      consumer accepts the result
//   out_data       operand shifted left by out_lzc, zero filled
//   out_lzc        leading-zero count, 0..DATA_W
//   out_zero       operand was all zeros
//   perf_scan_cyc  (LZDN_PERF_EN only) SCAN cycle counter, saturating

module lzd_norm_seq #(
  parameter int DATA_W = 48,
  parameter int LZC_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LZC_W-1:0]  out_lzc,
  output logic              out_zero
`ifdef LZDN_PERF_EN
  ,
  output logic [15:0]       perf_scan_cyc
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  wreg_reg,  wreg_next;
  logic [LZC_W-1:0]   cnt_reg,   cnt_next;
  logic [IDX_W-1:0]   idx_reg,   idx_next;
  logic               zero_reg,  zero_next;

  // ---------------------------------------------------------------------------
  // 8-bit leading-zero detector on the top byte of the working register.
  // any_above[i] says some bit above position (7-i) is set; the first set bit
  // is the one with nothing set above it, and its distance from bit 7 is p.
  // ---------------------------------------------------------------------------
  logic [7:0] top_byte;
  logic [8:0] any_above;
  logic [7:0] first_one;
  logic [2:0] lzd_p;
  logic       lzd_v;

  assign top_byte     = wreg_reg[DATA_W-1 -: 8];
  assign any_above[0] = 1'b0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lzd
    assign any_above[gi+1] = any_above[gi] | top_byte[7-gi];
    assign first_one[gi]   = top_byte[7-gi] & ~any_above[gi];
  end

  assign lzd_v = any_above[8];

  always_comb begin
    lzd_p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (first_one[i]) begin
        lzd_p = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wreg_reg  <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wreg_reg  <= wreg_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      zero_reg  <= zero_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, datapath updates, handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    wreg_next  = wreg_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    zero_next  = zero_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wreg_next  = in_data;
          cnt_next   = '0;
          idx_next   = '0;
          zero_next  = 1'b0;
          state_next = SCAN;
        end
      end

      SCAN: begin
        if (lzd_v) begin
          // First nonzero byte found: finish with a sub-byte shift.
          cnt_next   = cnt_reg + LZC_W'(lzd_p);
          wreg_next  = wreg_reg << lzd_p;
          state_next = DONE;
        end else if (idx_reg == IDX_W'(NB - 1)) begin
          // Last byte also zero: operand is all zeros.
          cnt_next   = LZC_W'(DATA_W);
          wreg_next  = '0;
          zero_next  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next   = cnt_reg + LZC_W'(8);
          wreg_next  = wreg_reg << 8;
          idx_next   = idx_reg + IDX_W'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // No bypass into a new accept: the block always passes through IDLE.
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Results are read straight from the working registers; they only change
  // in SCAN or on accept, so they are stable throughout DONE.
  assign out_data = wreg_reg;
  assign out_lzc  = cnt_reg;
  assign out_zero = zero_reg;

`ifdef LZDN_PERF_EN
  logic [15:0] perf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_reg <= '0;
    end else if (state_reg == SCAN && perf_reg != 16'hFFFF) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

  assign perf_scan_cyc = perf_reg;
`endif

endmodule

// File: tb/tb_lzd_norm_seq.sv
// tb_lzd_norm_seq
//   Scoreboard bench for lzd_norm_seq (DATA_W=48, LZC_W=6). The driver pushes
//   the expected result of each accepted operand into a queue; a monitor on the
//   falling edge compares whatever the DUT presents against the queue head.
//   The reference model counts leading zeros bit by bit and derives the
//   expected latency from that count.

module tb_lzd_norm_seq;

  localparam int DW = 48;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_lzc;
  logic          out_zero;
`ifdef LZDN_PERF_EN
  logic [15:0]   perf_scan_cyc;
`endif

  lzd_norm_seq #(.DATA_W(DW), .LZC_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lzc   (out_lzc),
    .out_zero  (out_zero)
`ifdef LZDN_PERF_EN
    ,
    .perf_scan_cyc (perf_scan_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] data;
    logic [LW-1:0] lzc;
    logic          zero;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  bit   busy = 1'b0;
  bit   seen = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count leading zeros bit by bit from the MSB. Latency is one
  // edge into SCAN plus one SCAN cycle per leading zero byte plus the byte
  // holding the first one (capped at the number of bytes).
  function automatic exp_t model(input logic [DW-1:0] d);
    exp_t e;
    int   lz = 0;
    int   s;
    while (lz < DW && d[DW-1-lz] == 1'b0) lz++;
    e.din  = d;
    e.lzc  = LW'(lz);
    e.zero = (lz == DW);
    e.data = (lz == DW) ? '0 : (d << lz);
    s      = (lz == DW) ? DW / 8 : lz / 8 + 1;
    e.lat  = s + 1;
    e.acc  = 0;
    return e;
  endfunction

  // Called at posedge+#1. Holds in_valid until the DUT is ready, then the
  // following edge is the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    exp_t e;
    int   waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
      return;
    end
    e     = model(d);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy     = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    busy = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: checks handshake state every cycle and compares held results.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(!busy));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          end
          chk("out_data", 64'(out_data), 64'(q[0].data));
          chk("out_lzc",  64'(out_lzc),  64'(q[0].lzc));
          chk("out_zero", 64'(out_zero), 64'(q[0].zero));
          if (out_ready) begin
            n_txn++;
            $display("txn %0d: in=%012h lzc=%0d zero=%0d data=%012h lat=%0d",
                     n_txn, q[0].din, out_lzc, out_zero, out_data, q[0].lat);
            void'(q.pop_front());
            seen = 1'b0;
            busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    int            lz;

    // Reset held for two edges, then check the idle state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_lzc",   64'(out_lzc),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_zero",  64'(out_zero),  64'd0);
    @(posedge clk); #1;

    // Directed operands.
    out_ready = 1'b1;
    send(48'h8000_0000_0000); wait_idle();
    send(48'h0000_0000_0013); wait_idle();
    send(48'h0000_0000_0000); wait_idle();
    send(48'h0000_0000_0001); wait_idle();
    send(48'hFFFF_FFFF_FFFF); wait_idle();

    // Backpressure with a stray in_valid while the result is held.
    out_ready = 1'b0;
    send(48'h0001_0000_0000);
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_data  = 48'hFFFF_0000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset during the third SCAN cycle of an all-zero operand.
    send(48'h0000_0000_0000);
    repeat (2) begin
      @(posedge clk); #1;
    end
    do_reset();
    repeat (10) begin
      @(posedge clk); #1;
    end
    send(48'h00FF_0000_0000); wait_idle();
`ifdef LZDN_PERF_EN
    chk("perf_scan_cyc", 64'(perf_scan_cyc), 64'd2);
`endif

    // Randomized operands with random leading-zero counts and random out_ready.
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      d  = {$urandom(), $urandom()} & {DW{1'b1}};
      lz = $urandom_range(0, DW);
      if (lz == DW) begin
        d = '0;
      end else begin
        d = d >> lz;
        d[DW-1-lz] = 1'b1;
      end
      send(d);
    end
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
